// File: rtl/rng_share_if.sv
// rng_share_if: request/grant bundle between the random-word
// arbiter and its consumers.
interface rng_share_if #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 16
);
  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ-1:0] ack;
  logic [DATA_W-1:0]  rnd_out;
  logic               busy;

  modport master (
    output req,
    input  ack,
    input  rnd_out,
    input  busy
  );

  modport slave (
    input  req,
    output ack,
    output rnd_out,
    output busy
  );
endinterface

// File: rtl/rng_share_arbiter.sv
// rng_share_arbiter: round-robin sharing of one LFSR word with a gap.
// Optional macro RNG_SHARE_WHITEN_EN mixes in the last delivered word.
module rng_share_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 16,
  parameter int MIN_GAP = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [DATA_W-1:0] rnd_number,
  rng_share_if.slave        bus
);

  localparam int PW = $clog2(NUM_REQ);
  localparam int CW = 4;
  localparam logic [NUM_REQ-1:0] ONE = NUM_REQ'(1);

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    GAP
  } state_t;

  state_t             st_q, st_n;
  logic [CW-1:0]      cnt_q, cnt_n;
  logic [PW-1:0]      ptr_q, ptr_n;
  logic [PW-1:0]      win;
  logic               hit;
  logic [NUM_REQ-1:0] ack_q, ack_n;
  logic [DATA_W-1:0]  rnd_q, rnd_n;
  logic [DATA_W-1:0]  word;
  int                 idx;

`ifdef RNG_SHARE_WHITEN_EN
  // rnd_q always holds the last delivered word, so it doubles as prev_out
  assign word = rnd_number ^
    {rnd_q[DATA_W-6:0], rnd_q[DATA_W-1:DATA_W-5]};
`else
  assign word = rnd_number;
`endif

  // first set req bit searching upward from ptr+1 with wrap
  always_comb begin
    hit = 1'b0;
    win = '0;
    idx = 0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx = int'(ptr_q) + i;
      if (idx >= NUM_REQ)
        idx = idx - NUM_REQ;
      if (!hit && bus.req[PW'(idx)]) begin
        hit = 1'b1;
        win = PW'(idx);
      end
    end
  end

  // next state; en=0 freezes everything except the ack pulse
  always_comb begin
    st_n  = st_q;
    cnt_n = cnt_q;
    ptr_n = ptr_q;
    ack_n = '0;
    rnd_n = rnd_q;
    unique case (st_q)
      IDLE: begin
        if (en && hit) begin
          ack_n = ONE << win;
          rnd_n = word;
          ptr_n = win;
          st_n  = GRANT;
        end
      end
      GRANT: begin
        if (en) begin
          if (MIN_GAP == 0) begin
            st_n = IDLE;
          end else begin
            cnt_n = CW'(MIN_GAP - 1);
            st_n  = GAP;
          end
        end
      end
      GAP: begin
        if (en) begin
          if (cnt_q == '0)
            st_n = IDLE;
          else
            cnt_n = cnt_q - CW'(1);
        end
      end
      default: st_n = IDLE;
    endcase
  end

  // state and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q  <= IDLE;
      cnt_q <= '0;
      ptr_q <= PW'(NUM_REQ - 1);
      ack_q <= '0;
      rnd_q <= '0;
    end else begin
      st_q  <= st_n;
      cnt_q <= cnt_n;
      ptr_q <= ptr_n;
      ack_q <= ack_n;
      rnd_q <= rnd_n;
    end
  end

  assign bus.ack     = ack_q;
  assign bus.rnd_out = rnd_q;
  assign bus.busy    = (st_q != IDLE);

  // grant pulses are one-hot and never back-to-back
  always_ff @(posedge clk) begin
    if (rst_n) begin
      assert ($onehot0(ack_q));
      assert (!((|ack_q) && (|ack_n)));
    end
  end

endmodule

// File: tb/tb_rng_share_arbiter.sv
// tb_rng_share_arbiter: directed and random checks against a
// grant/hold reference model.
module tb_rng_share_arbiter;

  localparam int N = 4;
  localparam int W = 16;
  localparam int G = 3;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         en = 1'b0;
  logic [W-1:0] rnd_v = '0;

  int n_run = 0;
  int n_fail = 0;
  int cyc = 0;

  // model: last winner, en-edges still to wait, outputs
  int           m_last = N - 1;
  int           m_hold = 0;
  logic [N-1:0] m_ack = '0;
  logic [W-1:0] m_rnd = '0;

  always #5 clk = ~clk;

  rng_share_if #(.NUM_REQ(N), .DATA_W(W)) bus ();

  rng_share_arbiter #(
    .NUM_REQ(N),
    .DATA_W (W),
    .MIN_GAP(G)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .rnd_number(rnd_v),
    .bus       (bus)
  );

  function automatic void m_reset();
    m_last = N - 1;
    m_hold = 0;
    m_ack  = '0;
    m_rnd  = '0;
  endfunction

  function automatic logic [W-1:0] m_mix(logic [W-1:0] p);
`ifdef RNG_SHARE_WHITEN_EN
    return (p << 5) | (p >> (W - 5));
`else
    return '0;
`endif
  endfunction

  function automatic void m_step(logic e, logic [N-1:0] r,
                                 logic [W-1:0] d);
    int w;
    int j;
    w = -1;
    m_ack = '0;
    if (m_hold > 0) begin
      if (e) m_hold--;
    end else if (e && r != '0) begin
      for (int k = 1; k <= N; k++) begin
        j = (m_last + k) % N;
        if (w < 0 && ((r >> j) & 1) != 0) w = j;
      end
      m_ack  = N'(1) << w;
      m_rnd  = d ^ m_mix(m_rnd);
      m_last = w;
      m_hold = G + 1;
    end
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_run++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    m_step(en, bus.req, rnd_v);
    cyc++;
    #1;
    chk("ack", 32'(bus.ack), 32'(m_ack));
    chk("rnd_out", 32'(bus.rnd_out), 32'(m_rnd));
    chk("busy", 32'(bus.busy), 32'(m_hold > 0));
  endtask

  task automatic wait_grant(output int who);
    who = -1;
    for (int t = 0; t < 40 && who < 0; t++) begin
      tick();
      if (bus.ack != '0) who = $clog2(bus.ack);
    end
    n_run++;
    assert (who >= 0) else begin
      n_fail++;
      $error("FAIL wait_grant observed=none expected=grant");
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    int who;
    int got;
    int at_c [5];
    int id_c [5];
    bus.req = '0;

    // reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ack", 32'(bus.ack), 32'h0);
    chk("rst_rnd", 32'(bus.rnd_out), 32'h0);
    chk("rst_busy", 32'(bus.busy), 32'h0);
    rst_n = 1'b1;
    en = 1'b1;
    tick();

    // single grant, 1-cycle latency
    bus.req = 4'b0001;
    rnd_v = 16'hBEEF;
    tick();
    chk("first_ack", 32'(bus.ack), 32'h1);
    chk("first_rnd", 32'(bus.rnd_out), 32'hBEEF);
    chk("first_busy", 32'(bus.busy), 32'h1);
    bus.req = '0;
    tick();
    chk("ack_clear", 32'(bus.ack), 32'h0);
    repeat (5) tick();

    // all requesting, fresh pointer
    do_reset();
    bus.req = 4'b1111;
    got = 0;
    for (int t = 0; t < 60 && got < 5; t++) begin
      rnd_v = W'($urandom);
      tick();
      if (bus.ack != '0) begin
        id_c[got] = $clog2(bus.ack);
        at_c[got] = cyc;
        got++;
      end
    end
    chk("rr_count", 32'(got), 32'd5);
    for (int g = 0; g < 5; g++) begin
      chk("rr_order", 32'(id_c[g]), 32'(g % N));
      if (g > 0)
        chk("rr_space", 32'(at_c[g] - at_c[g-1]), 32'(G + 2));
    end

    // wrap after requester 3
    bus.req = 4'b1000;
    wait_grant(who);
    chk("wrap_pre", 32'(who), 32'd3);
    bus.req = 4'b1001;
    wait_grant(who);
    chk("wrap_0", 32'(who), 32'd0);
    bus.req = 4'b1000;
    wait_grant(who);
    chk("wrap_3", 32'(who), 32'd3);
    bus.req = '0;

    // en=0 while gap counter is 1
    bus.req = 4'b0001;
    wait_grant(who);
    bus.req = '0;
    tick();
    tick();
    en = 1'b0;
    bus.req = 4'b0010;
    for (int t = 0; t < 10; t++) begin
      tick();
      chk("frz_ack", 32'(bus.ack), 32'h0);
      chk("frz_busy", 32'(bus.busy), 32'h1);
    end
    en = 1'b1;
    wait_grant(who);
    chk("frz_who", 32'(who), 32'd1);
    bus.req = '0;
    repeat (6) tick();

    // async reset during the grant cycle
    bus.req = 4'b0001;
    wait_grant(who);
    bus.req = '0;
    #2;
    rst_n = 1'b0;
    m_reset();
    #1;
    chk("arst_ack", 32'(bus.ack), 32'h0);
    chk("arst_busy", 32'(bus.busy), 32'h0);
    chk("arst_rnd", 32'(bus.rnd_out), 32'h0);
    rst_n = 1'b1;
    bus.req = 4'b0100;
    wait_grant(who);
    chk("arst_who", 32'(who), 32'd2);
    bus.req = '0;
    do_reset();
    bus.req = 4'b0101;
    wait_grant(who);
    chk("arst_ptr", 32'(who), 32'd0);
    bus.req = '0;
    repeat (6) tick();

`ifdef RNG_SHARE_WHITEN_EN
    do_reset();
    rnd_v = 16'h0001;
    bus.req = 4'b0001;
    tick();
    chk("wht_1", 32'(bus.rnd_out), 32'h0001);
    bus.req = '0;
    repeat (5) tick();
    rnd_v = 16'h0000;
    bus.req = 4'b0001;
    tick();
    chk("wht_2", 32'(bus.rnd_out), 32'h0020);
    bus.req = '0;
    repeat (5) tick();
`endif

    // random traffic; consumers drop req on their ack
    do_reset();
    for (int t = 0; t < 500; t++) begin
      en = ($urandom_range(7) != 0);
      rnd_v = W'($urandom);
      for (int i = 0; i < N; i++) begin
        if (m_ack[i])
          bus.req[i] = 1'b0;
        else if (!bus.req[i] && $urandom_range(3) == 0)
          bus.req[i] = 1'b1;
        else if ($urandom_range(15) == 0)
          bus.req[i] = 1'b0;
      end
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
